// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  // Fetch state machine encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    KILL = 2'd3
  } fetch_state_t;

  // Instructions are one 32-bit word, so the PC advances by a word.
  localparam logic [31:0] PC_INC = 32'd4;

  // PC loaded on reset when the instantiating module does not override it.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundles the instruction-memory bus, the decode handshake and the
// branch-redirect inputs seen by the fetch sequencer.
interface fetch_sequencer_if;

  // Instruction-memory request/ack bus.
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  // Decode-side valid/stall handshake.
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        stall;

  // Branch redirect from later pipeline stages.
  logic        branch_taken;
  logic [31:0] branch_target;

  // Sequencer side.
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_rdata, stall, branch_taken, branch_target
  );

  // Memory / decode / branch-unit side.
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_rdata, stall, branch_taken, branch_target
  );

endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues one memory request at a
// time, presents each fetched word to decode and applies branch redirects,
// discarding any fetch that was already in flight when the redirect arrived.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  fetch_sequencer_if.master bus
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic [31:0]  redirect_pc_reg, redirect_pc_next;
  logic [31:0]  instr_reg, instr_next;
  logic [31:0]  instr_pc_reg, instr_pc_next;
  logic [31:0]  branch_tgt;

  // Branch targets are word aligned; the low two address bits are forced to 0.
  assign branch_tgt = bus.branch_target & ~32'h0000_0003;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      pc_reg          <= RESET_PC;
      redirect_pc_reg <= 32'h0;
      instr_reg       <= 32'h0;
      instr_pc_reg    <= 32'h0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      redirect_pc_reg <= redirect_pc_next;
      instr_reg       <= instr_next;
      instr_pc_reg    <= instr_pc_next;
    end
  end

  // Next-state logic with inline next-PC mux and incrementer.
  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    redirect_pc_next = redirect_pc_reg;
    instr_next       = instr_reg;
    instr_pc_next    = instr_pc_reg;

    unique case (state_reg)
      IDLE: begin
        state_next = REQ;
      end

      REQ: begin
        if (bus.imem_ack && bus.branch_taken) begin
          // Returned word belongs to the old path: drop it and refetch.
          pc_next = branch_tgt;
        end else if (bus.imem_ack) begin
          instr_next    = bus.imem_rdata;
          instr_pc_next = pc_reg;
          pc_next       = pc_reg + PC_INC;
          state_next    = HOLD;
        end else if (bus.branch_taken) begin
          // Request is still outstanding; pc stays put so the address
          // remains stable until memory acks.
          redirect_pc_next = branch_tgt;
          state_next       = KILL;
        end
      end

      KILL: begin
        if (bus.imem_ack) begin
          pc_next    = bus.branch_taken ? branch_tgt : redirect_pc_reg;
          state_next = REQ;
        end else if (bus.branch_taken) begin
          redirect_pc_next = branch_tgt;
        end
      end

      HOLD: begin
        if (bus.branch_taken) begin
          // Redirect wins over stall; the held word is dropped.
          pc_next    = branch_tgt;
          state_next = REQ;
        end else if (!bus.stall) begin
          state_next = REQ;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    bus.imem_req    = (state_reg == REQ) || (state_reg == KILL);
    bus.imem_addr   = pc_reg;
    bus.instr_valid = (state_reg == HOLD);
    bus.instr       = instr_reg;
    bus.instr_pc    = instr_pc_reg;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: the bench plays memory, decode and the
// branch unit, observing and driving on the falling edge of the clock.
module tb_fetch_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fetch_sequencer_if bus ();

  fetch_sequencer #(
    .RESET_PC(32'h0000_0100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock: through the rising edge, back to the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic ack, input logic [31:0] rdata,
                       input logic br, input logic [31:0] tgt, input logic stl);
    bus.imem_ack      = ack;
    bus.imem_rdata    = rdata;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    bus.stall         = stl;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: req=%b valid=%b required req=0 valid=0", bus.imem_req, bus.instr_valid);
    end
    checks++;
    if (bus.instr !== 32'h0 || bus.instr_pc !== 32'h0 || bus.imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL reset_data: instr=%h pc=%h addr=%h required 0/0/100", bus.instr, bus.instr_pc, bus.imem_addr);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_cycle: req=%b required 0", bus.imem_req);
    end
    $display("reset: released, IDLE observed");
  endtask

  task automatic test_first_fetch();
    step();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h required 1/00000100", bus.imem_req, bus.imem_addr);
    end
    drive(1'b1, 32'hAAAA_0001, 1'b0, 32'h0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr !== 32'hAAAA_0001 || bus.instr_pc !== 32'h100 || bus.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL first_instr: valid=%b instr=%h pc=%h req=%b required 1/aaaa0001/00000100/0",
               bus.instr_valid, bus.instr, bus.instr_pc, bus.imem_req);
    end
    step();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h104) begin
      errors++;
      $display("FAIL second_req: req=%b addr=%h required 1/00000104", bus.imem_req, bus.imem_addr);
    end
    $display("first_fetch: addr 100 -> aaaa0001, next request 104");
  endtask

  task automatic test_latency();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h104 || bus.instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL latency_wait%0d: req=%b addr=%h valid=%b required 1/00000104/0",
                 c, bus.imem_req, bus.imem_addr, bus.instr_valid);
      end
      if (c == 2) drive(1'b1, 32'hBBBB_0002, 1'b0, 32'h0, 1'b0);
      else        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr !== 32'hBBBB_0002 || bus.instr_pc !== 32'h104) begin
      errors++;
      $display("FAIL latency_instr: valid=%b instr=%h pc=%h required 1/bbbb0002/00000104",
               bus.instr_valid, bus.instr, bus.instr_pc);
    end
    $display("latency: 3-cycle ack at 104 -> bbbb0002");
  endtask

  task automatic test_stall();
    // Stall is already high; hold it for four HOLD cycles.
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== 32'hBBBB_0002 || bus.instr_pc !== 32'h104 || bus.imem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: valid=%b instr=%h pc=%h req=%b required 1/bbbb0002/00000104/0",
                 c, bus.instr_valid, bus.instr, bus.instr_pc, bus.imem_req);
      end
      if (c == 3) drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      step();
    end
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h108 || bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: req=%b addr=%h valid=%b required 1/00000108/0",
               bus.imem_req, bus.imem_addr, bus.instr_valid);
    end
    $display("stall: held 4 cycles, then request 108");
  endtask

  task automatic test_branch_kill();
    drive(1'b0, 32'h0, 1'b1, 32'h0000_2003, 1'b0);
    step();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h108 || bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL kill_hold1: req=%b addr=%h valid=%b required 1/00000108/0",
               bus.imem_req, bus.imem_addr, bus.instr_valid);
    end
    drive(1'b0, 32'h0, 1'b1, 32'h0000_3000, 1'b0);
    step();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h108 || bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL kill_hold2: req=%b addr=%h valid=%b required 1/00000108/0",
               bus.imem_req, bus.imem_addr, bus.instr_valid);
    end
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
    step();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3000 || bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL kill_redirect: req=%b addr=%h valid=%b required 1/00003000/0",
               bus.imem_req, bus.imem_addr, bus.instr_valid);
    end
    drive(1'b1, 32'hCCCC_0003, 1'b0, 32'h0, 1'b0);
    step();
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr !== 32'hCCCC_0003 || bus.instr_pc !== 32'h3000) begin
      errors++;
      $display("FAIL kill_next_instr: valid=%b instr=%h pc=%h required 1/cccc0003/00003000",
               bus.instr_valid, bus.instr, bus.instr_pc);
    end
    $display("branch_kill: 2003 then 3000 during flight, refetch 3000 -> cccc0003");
  endtask

  task automatic test_branch_hold_wrap();
    // Redirect in HOLD with stall high; target is the last word of memory.
    drive(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFE, 1'b1);
    step();
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL hold_branch: valid=%b req=%b addr=%h required 0/1/fffffffc",
               bus.instr_valid, bus.imem_req, bus.imem_addr);
    end
    drive(1'b1, 32'hEEEE_0004, 1'b0, 32'h0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr !== 32'hEEEE_0004 || bus.instr_pc !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_instr: valid=%b instr=%h pc=%h required 1/eeee0004/fffffffc",
               bus.instr_valid, bus.instr, bus.instr_pc);
    end
    step();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_next: req=%b addr=%h required 1/00000000", bus.imem_req, bus.imem_addr);
    end
    $display("branch_hold_wrap: fffffffc fetched, next request 00000000");
  endtask

  task automatic test_back_to_back();
    // Ack and branch together in REQ: data dropped, target requested at once.
    drive(1'b1, 32'h1111_1111, 1'b1, 32'h0000_0500, 1'b0);
    step();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h500 || bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL ack_branch: req=%b addr=%h valid=%b required 1/00000500/0",
               bus.imem_req, bus.imem_addr, bus.instr_valid);
    end
    drive(1'b1, 32'h2222_2222, 1'b0, 32'h0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h2222_2222 || bus.instr_pc !== 32'h500) begin
      errors++;
      $display("FAIL b2b_instr: valid=%b instr=%h pc=%h required 1/22222222/00000500",
               bus.instr_valid, bus.instr, bus.instr_pc);
    end
    step();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h504) begin
      errors++;
      $display("FAIL b2b_next: req=%b addr=%h required 1/00000504", bus.imem_req, bus.imem_addr);
    end
    $display("back_to_back: ack+branch to 500, then 22222222, next 504");
  endtask

  task automatic test_mid_reset();
    // In REQ with a request outstanding; reset must act without a clock edge.
    rst = 1'b1;
    #1;
    checks++;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.instr !== 32'h0 ||
        bus.instr_pc !== 32'h0 || bus.imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL mid_reset: req=%b valid=%b instr=%h pc=%h addr=%h required 0/0/0/0/100",
               bus.imem_req, bus.instr_valid, bus.instr, bus.instr_pc, bus.imem_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL restart: req=%b addr=%h required 1/00000100", bus.imem_req, bus.imem_addr);
    end
    $display("mid_reset: outputs cleared, restart at 100");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_first_fetch();
    test_latency();
    test_stall();
    test_branch_kill();
    test_branch_hold_wrap();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
